sram_host_driver: RTL and testbench

Host-side sequencer that drives the 8-pin nibble-serial SRAM tile (pin map: [0] SRAM clock, [1] we, [2] oe, [3] commit, [7:4] address/data nibble). It accepts byte-wide write, read and burst-read requests on a valid/ready port and generates the SRAM's pin waveform, including its clock. It samples the SRAM's 8-bit output through a synchronizer and returns read bytes on a response strobe. It sits directly upstream of the SRAM tile, on the board FPGA or a neighbouring tile.

---
 rtl/sram_pin_pkg.sv | 29 ++
 rtl/sram_pin_sync.sv | 17 +
 rtl/sram_host_driver.sv | 110 +++++++++++
 tb/tb_sram_host_driver.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pin_pkg.sv
// sram_pin_pkg: pin map, op codes, FSM states and pin-word encoder for the nibble-serial SRAM tile
package sram_pin_pkg;
    localparam int PIN_CLK    = 0;
    localparam int PIN_WE     = 1;
    localparam int PIN_OE     = 2;
    localparam int PIN_COMMIT = 3;
    localparam int NIB_LSB    = 4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_BURST = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_SEQ_L, ST_SEQ_H, ST_DONE} state_t;

    function automatic logic [7:0] pin_word(input logic [1:0] op, input logic [4:0] pc,
                                            input logic [3:0] addr, input logic [7:0] wdata,
                                            input logic clk_hi);
        logic [7:0] w;
        w = '0;
        w[PIN_CLK]      = clk_hi;
        w[PIN_WE]       = (op == OP_WRITE && pc != 5'd2) || op == OP_BURST;
        w[PIN_OE]       = op == OP_READ || op == OP_BURST;
        w[PIN_COMMIT]   = (op == OP_WRITE && pc == 5'd2) || (op == OP_BURST && pc == 5'd0);
        w[NIB_LSB +: 4] = op == OP_WRITE ? (pc == 5'd0 ? wdata[3:0] : pc == 5'd1 ? wdata[7:4] : addr)
                        : (op == OP_BURST && pc != 5'd0) ? 4'h0 : addr;
        return w;
    endfunction
endpackage

// File: rtl/sram_pin_sync.sv
// sram_pin_sync: multi-stage 8-bit flop synchronizer for the asynchronous SRAM output pins
module sram_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_d,
    output logic [7:0] o_q
);
    logic [STAGES-1:0][7:0] r_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_q <= '0;
        else       r_q <= {r_q[STAGES-2:0], i_d};

    assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/sram_host_driver.sv
// sram_host_driver: sequences write/read/burst requests into the SRAM tile pin waveform
module sram_host_driver
    import sram_pin_pkg::*;
#(
    parameter int HALF        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic [7:0] sram_in,
    input  logic [7:0] sram_out
);
    state_t     r_state, w_nxt;
    logic [7:0] r_ph, w_ph;
    logic [4:0] r_pc, w_pc, r_last;
    logic [1:0] r_op, w_op;
    logic [3:0] r_addr, w_addr;
    logic [7:0] r_wdata, w_wdata, w_sync, r_pins, r_rdata;
    logic       r_ready, r_busy, r_rsp, w_acc, w_end, w_seq, w_sample;

    sram_pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (sram_out),
        .o_q   (w_sync)
    );

    assign w_acc    = req_valid && r_ready && r_state == ST_IDLE;
    assign w_end    = r_ph == 8'(HALF - 1);
    assign w_op     = w_acc ? req_op : r_op;
    assign w_addr   = w_acc ? req_addr : r_addr;
    assign w_wdata  = w_acc ? req_wdata : r_wdata;
    assign w_seq    = w_nxt == ST_SEQ_L || w_nxt == ST_SEQ_H;
    // Pin cycle 0 of a burst only loads the stream index, so it is never sampled
    assign w_sample = r_state == ST_SEQ_H && w_end &&
                      (r_op == OP_READ || (r_op == OP_BURST && r_pc != 5'd0));

    always_comb begin
        w_nxt = r_state;
        w_ph  = r_ph + 8'd1;
        w_pc  = r_pc;
        case (r_state)
            ST_IDLE: begin
                w_ph = '0;
                w_pc = '0;
                if (w_acc) w_nxt = req_op == OP_RSVD ? ST_DONE : ST_SEQ_L;
            end
            ST_SEQ_L: if (w_end) begin
                w_nxt = ST_SEQ_H;
                w_ph  = '0;
            end
            ST_SEQ_H: if (w_end) begin
                w_nxt = r_pc == r_last ? ST_DONE : ST_SEQ_L;
                w_ph  = '0;
                w_pc  = r_pc + 5'd1;
            end
            default: begin
                w_nxt = ST_IDLE;
                w_ph  = '0;
            end
        endcase
    end

    // Pins are registered from the next state so they line up exactly with the FSM phases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ph    <= '0;
            r_pc    <= '0;
            r_last  <= '0;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pins  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_rsp   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_nxt;
            r_ph    <= w_ph;
            r_pc    <= w_pc;
            if (w_acc) begin
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_last  <= req_op == OP_WRITE ? 5'd2 : req_op == OP_BURST ? 5'(req_wdata[3:0]) + 5'd1 : 5'd0;
            end
            r_pins  <= w_seq ? pin_word(w_op, w_pc, w_addr, w_wdata, w_nxt == ST_SEQ_H) : 8'h00;
            r_ready <= w_nxt == ST_IDLE;
            r_busy  <= w_nxt != ST_IDLE;
            r_rsp   <= w_sample;
            if (w_sample) r_rdata <= w_sync;
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp;
    assign rsp_rdata = r_rdata;
    assign sram_in   = r_pins;
endmodule

// File: tb/tb_sram_host_driver.sv
// tb_sram_host_driver: scenario tasks against a behavioral SRAM tile, with a response scoreboard
module tb_sram_host_driver;
    import sram_pin_pkg::*;

    localparam int HALF = 4;
    localparam int PC   = 2 * HALF;

    typedef struct {
        int         at;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [3:0] req_addr = 4'h0;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready, rsp_valid, busy;
    logic [7:0] rsp_rdata, sram_in, sram_out;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         viol = 0;
    exp_t       sb[$];
    logic [7:0] exp_mem[16];
    logic [7:0] mem[16];
    logic [7:0] wbuf;
    logic [3:0] idx;
    logic [7:0] prev_pins = 8'h00;

    sram_host_driver #(.HALF(HALF), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sram_in   (sram_in),
        .sram_out  (sram_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // SRAM tile model: acts on each rising SRAM clock, output settles a little later
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 37 + 11);
        sram_out = 8'h00;
        wbuf = 8'h00;
        idx = 4'h0;
        forever begin
            @(posedge sram_in[0]);
            #2;
            case ({sram_in[PIN_WE], sram_in[PIN_OE], sram_in[PIN_COMMIT]})
                3'b111: idx = sram_in[7:4];
                3'b110: begin sram_out = mem[idx]; idx = idx + 4'd1; end
                3'b100: wbuf = {sram_in[7:4], wbuf[7:4]};
                3'b001: mem[sram_in[7:4]] = wbuf;
                3'b010: sram_out = mem[sram_in[7:4]];
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && rsp_valid) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: rdata=%h at cycle %0d, required no strobe", rsp_rdata, cyc);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.data || cyc != e.at) begin
                    n_fail++;
                    $display("FAIL rsp: rdata=%h at cycle %0d, required %h at cycle %0d", rsp_rdata, cyc, e.data, e.at);
                end
            end
        end
        if (!reset && sram_in[0] && sram_in[7:1] !== prev_pins[7:1]) viol++;
        prev_pins = sram_in;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d, output int a0);
        int k;
        k = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: req_ready=%b, required 1", req_ready);
        end
        req_op = op;
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        a0 = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        int a0;
        issue(OP_WRITE, a, d, a0);
        repeat (3 * PC + 2) @(negedge clk);
        exp_mem[a] = d;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_tests++;
        if ({sram_in, req_ready, busy, rsp_valid, rsp_rdata} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_vals: sram_in=%h ready=%b busy=%b rsp=%b rdata=%h, required all 0",
                     sram_in, req_ready, busy, rsp_valid, rsp_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b busy=%b, required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_write;
        int a0;
        logic [3:0] nib[3];
        logic [3:0] ctl[3];
        logic [7:0] exp;
        nib[0] = 4'h5; nib[1] = 4'hA; nib[2] = 4'h3;
        ctl[0] = 4'h2; ctl[1] = 4'h2; ctl[2] = 4'h8;
        issue(OP_WRITE, 4'd3, 8'hA5, a0);
        for (int t = 1; t <= 3 * PC + 2; t++) begin
            @(negedge clk);
            exp = 8'h00;
            if (t <= 3 * PC) exp = {nib[(t - 1) / PC], ctl[(t - 1) / PC]} | 8'(((t - 1) % PC) >= HALF);
            n_tests++;
            if (sram_in !== exp) begin
                n_fail++;
                $display("FAIL write_pins t=%0d: sram_in=%h, required %h", t, sram_in, exp);
            end
            if (t >= 3 * PC + 1) begin
                n_tests++;
                if (req_ready !== (t == 3 * PC + 2) || busy !== (t == 3 * PC + 1)) begin
                    n_fail++;
                    $display("FAIL write_ready t=%0d: ready=%b busy=%b", t, req_ready, busy);
                end
            end
        end
        exp_mem[3] = 8'hA5;
    endtask

    task automatic test_read;
        int a0;
        exp_t e;
        logic [7:0] exp;
        issue(OP_READ, 4'd3, 8'h00, a0);
        e.at = a0 + PC + 1;
        e.data = exp_mem[3];
        sb.push_back(e);
        for (int t = 1; t <= PC + 3; t++) begin
            @(negedge clk);
            exp = t <= PC ? (8'h34 | 8'((t - 1) >= HALF)) : 8'h00;
            n_tests++;
            if (sram_in !== exp) begin
                n_fail++;
                $display("FAIL read_pins t=%0d: sram_in=%h, required %h", t, sram_in, exp);
            end
            if (t == PC + 1 || t == PC + 2) begin
                n_tests++;
                if (req_ready !== (t == PC + 2)) begin
                    n_fail++;
                    $display("FAIL read_ready t=%0d: ready=%b", t, req_ready);
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL read_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_burst_wrap;
        int a0;
        exp_t e;
        logic [7:0] exp;
        logic [3:0] ai;
        do_write(4'd14, 8'h11);
        do_write(4'd15, 8'h22);
        do_write(4'd0, 8'h33);
        issue(OP_BURST, 4'd14, 8'h02, a0);
        for (int k = 1; k <= 3; k++) begin
            ai = 4'd14 + 4'(k - 1);
            e.at = a0 + PC * (k + 1) + 1;
            e.data = exp_mem[ai];
            sb.push_back(e);
        end
        for (int t = 1; t <= 4 * PC + 2; t++) begin
            @(negedge clk);
            exp = t > 4 * PC ? 8'h00 : (t <= PC ? 8'hEE : 8'h06) | 8'(((t - 1) % PC) >= HALF);
            n_tests++;
            if (sram_in !== exp) begin
                n_fail++;
                $display("FAIL burst_pins t=%0d: sram_in=%h, required %h", t, sram_in, exp);
            end
        end
        n_tests++;
        if (req_ready !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL burst_done: ready=%b outstanding=%0d, required 1 0", req_ready, sb.size());
        end
    endtask

    task automatic test_burst_max;
        int a0;
        exp_t e;
        issue(OP_BURST, 4'd0, 8'h0F, a0);
        for (int k = 1; k <= 16; k++) begin
            e.at = a0 + PC * (k + 1) + 1;
            e.data = exp_mem[k - 1];
            sb.push_back(e);
        end
        for (int t = 1; t <= 17 * PC + 2; t++) begin
            @(negedge clk);
            if (t == 17 * PC + 1 || t == 17 * PC + 2) begin
                n_tests++;
                if (req_ready !== (t == 17 * PC + 2) || sram_in !== 8'h00) begin
                    n_fail++;
                    $display("FAIL burst16_end t=%0d: ready=%b sram_in=%h", t, req_ready, sram_in);
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL burst16_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_write;
        int a0;
        exp_t e;
        do_write(4'd7, 8'h0F);
        issue(OP_WRITE, 4'd7, 8'h5A, a0);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if (sram_in !== 8'h00 || req_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: sram_in=%h ready=%b busy=%b rsp=%b, required 0", sram_in, req_ready, busy, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: ready=%b, required 1", req_ready);
        end
        issue(OP_READ, 4'd7, 8'h00, a0);
        e.at = a0 + PC + 1;
        e.data = exp_mem[7];
        sb.push_back(e);
        repeat (PC + 2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        int a0;
        int k;
        exp_t e;
        k = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        req_op = OP_READ;
        req_addr = 4'd3;
        req_valid = 1'b1;
        a0 = cyc;
        e.at = a0 + PC + 1;
        e.data = exp_mem[3];
        sb.push_back(e);
        e.at = a0 + 2 * PC + 3;
        e.data = exp_mem[14];
        sb.push_back(e);
        @(posedge clk);
        #1 req_addr = 4'd14;
        for (int t = 1; t <= PC + 2; t++) begin
            @(negedge clk);
            n_tests++;
            if (req_ready !== (t == PC + 2)) begin
                n_fail++;
                $display("FAIL b2b_ready t=%0d: ready=%b, required %b", t, req_ready, t == PC + 2);
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (sram_in !== 8'hE4) begin
            n_fail++;
            $display("FAIL b2b_second_pins: sram_in=%h, required e4", sram_in);
        end
        repeat (PC + 2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reserved;
        int a0;
        issue(OP_RSVD, 4'd5, 8'hFF, a0);
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            n_tests++;
            if (sram_in !== 8'h00) begin
                n_fail++;
                $display("FAIL rsvd_pins t=%0d: sram_in=%h, required 00", t, sram_in);
            end
            if (t <= 2) begin
                n_tests++;
                if (req_ready !== (t == 2) || busy !== (t == 1)) begin
                    n_fail++;
                    $display("FAIL rsvd_ready t=%0d: ready=%b busy=%b", t, req_ready, busy);
                end
            end
        end
    endtask

    task automatic test_hygiene;
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL pin_hygiene: %0d changes while SRAM clock high, required 0", viol);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'(i * 37 + 11);
        test_reset;
        test_write;
        test_read;
        test_burst_wrap;
        test_burst_max;
        test_reset_mid_write;
        test_back_to_back;
        test_reserved;
        test_hygiene;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
